transition_bank: RTL

Multi-channel edge-event detector with per-channel lockout, the parametrised successor to the single-channel rising-edge/timeout block. Each channel synchronises an asynchronous input (button, switch, external strobe), detects a mode-selected edge, emits a one-cycle TRANS pulse, then ignores that channel for LOCKOUT cycles. Sticky PENDING/DROPPED flags let slow control logic poll events instead of catching pulses. Sits between board I/O and the overlay control FSMs.

---
 rtl/transition_pkg.sv | 18 +
 rtl/transition_chan.sv | 88 ++++++++
 rtl/transition_bank.sv | 37 +++
 3 files changed

// File: rtl/transition_pkg.sv
// Shared definitions for the edge-event bank: mode encodings and counter sizing.
// No logic and no latency; constants and a sizing helper only.
// No flow control involved.
package transition_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    // Lockout counter must hold LOCKOUT itself; never narrower than one bit.
    function automatic int cnt_width(input int lockout);
        return (lockout < 1) ? 1 : $clog2(lockout + 1);
    endfunction

endpackage

// File: rtl/transition_chan.sv
// One channel: synchroniser, mode-selected edge detect, lockout counter, sticky flags.
// Latency: SYNC_STAGES+1 cycles from input change to registered o_trans pulse.
// No backpressure: edges seen during lockout are dropped and flagged, never queued.
module transition_chan
    import transition_pkg::*;
#(
    parameter int LOCKOUT     = 20000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_signal,
    input  logic [1:0] i_mode,
    input  logic       i_clear,
    output logic       o_trans,
    output logic       o_busy,
    output logic       o_pending,
    output logic       o_dropped
);

    localparam int            CW   = cnt_width(LOCKOUT);
    localparam logic [CW-1:0] LOAD = CW'(LOCKOUT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_trans;
    logic                   r_pending;
    logic                   r_dropped;
    logic [CW-1:0]          r_cnt;

    logic w_s;
    logic w_qual;
    logic w_idle;
    logic w_accept;
    logic w_drop;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_idle   = (r_cnt == '0);
    assign w_accept = w_qual & w_idle;
    assign w_drop   = w_qual & ~w_idle;

    always_comb begin
        w_qual = 1'b0;
        case (mode_e'(i_mode))
            MODE_RISE: w_qual = w_s & ~r_prev;
            MODE_FALL: w_qual = ~w_s & r_prev;
            MODE_BOTH: w_qual = w_s ^ r_prev;
            default:   w_qual = 1'b0;
        endcase
    end

    // r_prev follows the synchroniser in every mode so a mode switch never fabricates an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_trans   <= 1'b0;
            r_pending <= 1'b0;
            r_dropped <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_signal};
            r_prev  <= w_s;
            r_trans <= w_accept;

            if (w_accept)
                r_cnt <= LOAD;
            else if (!w_idle)
                r_cnt <= r_cnt - CW'(1);

            if (w_accept)
                r_pending <= 1'b1;
            else if (i_clear)
                r_pending <= 1'b0;

            if (w_drop)
                r_dropped <= 1'b1;
            else if (i_clear)
                r_dropped <= 1'b0;
        end
    end

    assign o_trans   = r_trans;
    assign o_busy    = ~w_idle;
    assign o_pending = r_pending;
    assign o_dropped = r_dropped;

endmodule

// File: rtl/transition_bank.sv
// Bank of independent edge-event channels with per-channel lockout and sticky flags.
// Latency: SYNC_STAGES+1 cycles input to o_trans; no backpressure, edges in lockout are dropped.
// Top level only slices the buses across channel instances.
module transition_bank #(
    parameter int CHANNELS    = 4,
    parameter int LOCKOUT     = 20000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CHANNELS-1:0]   i_signal,
    input  logic [2*CHANNELS-1:0] i_mode,
    input  logic [CHANNELS-1:0]   i_clear,
    output logic [CHANNELS-1:0]   o_trans,
    output logic [CHANNELS-1:0]   o_busy,
    output logic [CHANNELS-1:0]   o_pending,
    output logic [CHANNELS-1:0]   o_dropped
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        transition_chan #(
            .LOCKOUT     (LOCKOUT),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_signal  (i_signal[g]),
            .i_mode    (i_mode[2*g +: 2]),
            .i_clear   (i_clear[g]),
            .o_trans   (o_trans[g]),
            .o_busy    (o_busy[g]),
            .o_pending (o_pending[g]),
            .o_dropped (o_dropped[g])
        );
    end

endmodule
